fetch_stage: RTL

Instruction-fetch stage directly upstream of the instruction memory. Owns the program counter, drives the memory address, and captures the returned instruction word and its PC into the IF/ID register for decode. Handles stall, taken-branch redirect with flush, a one-cycle boot state after reset, and a retired-fetch counter.

---
 rtl/fetch_stage.sv | 116 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address
// and captures the returned word into the IF/ID register.
// Optional feature macro: FETCH_MISALIGN_HALT_EN (halt on misaligned redirect).
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] imem_rd,
  output logic [31:0] imem_addr,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic        valid_q, valid_d;
  logic [31:0] cnt_q, cnt_d;
  logic        fault_q, fault_d;
  logic        misaligned;

`ifdef FETCH_MISALIGN_HALT_EN
  assign misaligned = (branch_target[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Next-state: BOOT holds one cycle, RUN applies branch > stall > capture.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    unique case (state_q)
      StBoot: begin
        state_d = StRun;
      end
      StRun: begin
        if (branch_taken) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          ifpc_d  = pc_q;
          if (misaligned) begin
            // PC is left untouched so the faulting fetch point stays visible.
            state_d = StHalt;
            fault_d = 1'b1;
          end else begin
            // Low bits dropped: only reachable with a misaligned target when
            // the halt feature is compiled out.
            pc_d = branch_target & 32'hFFFF_FFFC;
          end
        end else if (!stall) begin
          instr_d = imem_rd;
          ifpc_d  = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + 32'd4;
          cnt_d   = cnt_q + 32'd1;
        end
      end
      StHalt: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      ifpc_q  <= 32'h0;
      valid_q <= 1'b0;
      cnt_q   <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign imem_addr = pc_q;
  assign if_instr  = instr_q;
  assign if_pc     = ifpc_q;
  assign if_valid  = valid_q;
  assign fetch_cnt = cnt_q;

`ifdef FETCH_MISALIGN_HALT_EN
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

endmodule
